// File: rtl/ball_pool_move_if.sv
// Request and per-slot ball-state bus between the ball motion engine and the
// spawner, hit detector, drawers and collision logic.
interface ball_pool_move_if #(
    parameter int NUM_BALLS = 4
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    logic                     startOfFrame;
    logic                     spawn;
    logic [10:0]              spawnX;
    logic [10:0]              spawnY;
    logic [1:0]               spawnSize;
    logic                     spawnDirRight;
    logic                     hitValid;
    logic [IDX_W-1:0]         hitIdx;

    logic [NUM_BALLS-1:0]     active;
    logic [NUM_BALLS*11-1:0]  topLeftX;
    logic [NUM_BALLS*11-1:0]  topLeftY;
    logic [NUM_BALLS*2-1:0]   ballSize;
    logic [NUM_BALLS*16-1:0]  Xspeed;
    logic [NUM_BALLS*16-1:0]  Yspeed;
    logic                     allClear;
    logic                     spawnFail;
    logic                     splitFail;

    modport master (
        output startOfFrame, spawn, spawnX, spawnY, spawnSize, spawnDirRight,
               hitValid, hitIdx,
        input  active, topLeftX, topLeftY, ballSize, Xspeed, Yspeed,
               allClear, spawnFail, splitFail
    );

    modport slave (
        input  startOfFrame, spawn, spawnX, spawnY, spawnSize, spawnDirRight,
               hitValid, hitIdx,
        output active, topLeftX, topLeftY, ballSize, Xspeed, Yspeed,
               allClear, spawnFail, splitFail
    );
endinterface

// File: rtl/ball_pool_move.sv
// Fixed-point motion engine for a pool of bouncing balls: spawn, per-frame
// gravity/wall/floor/ceiling handling, and hit-driven split or destroy.
module ball_pool_move #(
    parameter int NUM_BALLS   = 4,
    parameter int FRAC_BITS   = 6,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int MIN_DIAM    = 8,
    parameter int GRAVITY     = 1,
    parameter int X_SPEED     = 64,
    parameter int BOUNCE_BASE = 256,
    parameter int BOUNCE_STEP = 64,
    parameter int SPLIT_SPEED = 192,
    parameter int MAX_YSPEED  = 512
) (
    input logic             clk,
    input logic             resetN,
    ball_pool_move_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BALLS);

    typedef logic signed [31:0] fix_t;

    typedef struct packed {
        logic       act;
        logic [1:0] size;
        logic       dir;
        fix_t       px;
        fix_t       py;
        fix_t       vy;
    } slot_t;

    localparam fix_t X_LO = fix_t'(X_MIN) <<< FRAC_BITS;
    localparam fix_t Y_LO = fix_t'(Y_MIN) <<< FRAC_BITS;

    slot_t            slot_q [NUM_BALLS];
    slot_t            slot_d [NUM_BALLS];
    logic             spawn_fail_q, spawn_fail_d;
    logic             split_fail_q, split_fail_d;
    logic             hit_ok, child_ok, spawn_ok, split_claim;
    logic [IDX_W-1:0] hit_i, child_i, spawn_i;
    logic [NUM_BALLS-1:0] act_vec;

    // One frame of motion for an active ball; limits scale with ball diameter.
    function automatic slot_t step(input slot_t s);
        slot_t n;
        fix_t  vy, nx, ny, diam, r_lim, f_lim;
        n     = s;
        vy    = s.vy + fix_t'(GRAVITY);
        if (vy > fix_t'(MAX_YSPEED))
            vy = fix_t'(MAX_YSPEED);
        else if (vy < -fix_t'(MAX_YSPEED))
            vy = -fix_t'(MAX_YSPEED);
        diam  = fix_t'(MIN_DIAM) << s.size;
        r_lim = (fix_t'(X_MAX) - diam + fix_t'(1)) <<< FRAC_BITS;
        f_lim = (fix_t'(Y_MAX) - diam + fix_t'(1)) <<< FRAC_BITS;
        nx    = s.dir ? s.px + fix_t'(X_SPEED) : s.px - fix_t'(X_SPEED);
        ny    = s.py + vy;

        if (s.dir && nx >= r_lim) begin
            n.px  = r_lim;
            n.dir = 1'b0;
        end else if (!s.dir && nx <= X_LO) begin
            n.px  = X_LO;
            n.dir = 1'b1;
        end else begin
            n.px  = nx;
        end

        if (ny >= f_lim && vy > fix_t'(0)) begin
            n.py = f_lim;
            n.vy = -(fix_t'(BOUNCE_BASE) + fix_t'({30'd0, s.size}) * fix_t'(BOUNCE_STEP));
        end else if (ny <= Y_LO && vy < fix_t'(0)) begin
            n.py = Y_LO;
            n.vy = fix_t'(0);
        end else begin
            n.py = ny;
            n.vy = vy;
        end
        return n;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        hit_ok       = 1'b0;
        hit_i        = '0;
        child_ok     = 1'b0;
        child_i      = '0;
        spawn_ok     = 1'b0;
        spawn_i      = '0;
        spawn_fail_d = 1'b0;
        split_fail_d = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            slot_d[i] = slot_q[i];
            if (bus.hitValid && bus.hitIdx == IDX_W'(i) && slot_q[i].act) begin
                hit_ok = 1'b1;
                hit_i  = IDX_W'(i);
            end
        end
        // Scan downwards so the lowest free index wins.
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (!slot_q[i].act) begin
                child_ok = 1'b1;
                child_i  = IDX_W'(i);
            end
        end
        split_claim = hit_ok && slot_q[hit_i].size != 2'd0 && child_ok;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (!slot_q[i].act && !(split_claim && child_i == IDX_W'(i))) begin
                spawn_ok = 1'b1;
                spawn_i  = IDX_W'(i);
            end
        end

        if (bus.startOfFrame) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (slot_q[i].act && !(hit_ok && hit_i == IDX_W'(i)))
                    slot_d[i] = step(slot_q[i]);
            end
        end

        if (hit_ok) begin
            if (slot_q[hit_i].size == 2'd0) begin
                slot_d[hit_i].act = 1'b0;
            end else begin
                slot_d[hit_i].size = slot_q[hit_i].size - 2'd1;
                slot_d[hit_i].dir  = 1'b0;
                slot_d[hit_i].vy   = -fix_t'(SPLIT_SPEED);
                if (child_ok)
                    slot_d[child_i] = '{act: 1'b1, size: slot_q[hit_i].size - 2'd1, dir: 1'b1,
                                        px: slot_q[hit_i].px, py: slot_q[hit_i].py,
                                        vy: -fix_t'(SPLIT_SPEED)};
                else
                    split_fail_d = 1'b1;
            end
        end

        if (bus.spawn) begin
            if (spawn_ok)
                slot_d[spawn_i] = '{act: 1'b1, size: bus.spawnSize, dir: bus.spawnDirRight,
                                    px: fix_t'({21'd0, bus.spawnX}) <<< FRAC_BITS,
                                    py: fix_t'({21'd0, bus.spawnY}) <<< FRAC_BITS,
                                    vy: fix_t'(0)};
            else
                spawn_fail_d = 1'b1;
        end
    end

    // NOTE: the slot array is a handful of registers, not a RAM, so it is reset like any flop.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BALLS; i++)
                slot_q[i] <= '0;
            spawn_fail_q <= 1'b0;
            split_fail_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            for (int i = 0; i < NUM_BALLS; i++)
                slot_q[i] <= slot_d[i];
            spawn_fail_q <= spawn_fail_d;
            split_fail_q <= split_fail_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++)
            act_vec[i] = slot_q[i].act;
    end

    always_comb begin
        bus.active    = act_vec;
        bus.allClear  = ~|act_vec;
        bus.spawnFail = spawn_fail_q;
        bus.splitFail = split_fail_q;
        bus.topLeftX  = '0;
        bus.topLeftY  = '0;
        bus.ballSize  = '0;
        bus.Xspeed    = '0;
        bus.Yspeed    = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (slot_q[i].act) begin
                bus.topLeftX[11*i +: 11] = slot_q[i].px[FRAC_BITS +: 11];
                bus.topLeftY[11*i +: 11] = slot_q[i].py[FRAC_BITS +: 11];
                bus.ballSize[2*i +: 2]   = slot_q[i].size;
                bus.Xspeed[16*i +: 16]   = slot_q[i].dir ? 16'(X_SPEED) : 16'(-X_SPEED);
                bus.Yspeed[16*i +: 16]   = slot_q[i].vy[15:0];
            end
        end
    end
endmodule

// File: tb/tb_ball_pool_move.sv
// Directed bench for ball_pool_move: spawn, motion, walls, floor, ceiling,
// split, pool exhaustion, same-cycle priority and asynchronous reset.
module tb_ball_pool_move;
    logic clk;
    logic resetN;
    int   passed;
    int   total;

    ball_pool_move_if #(.NUM_BALLS(4)) bus ();

    ball_pool_move #(.NUM_BALLS(4)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] x_of(input int i);
        return bus.topLeftX[11*i +: 11];
    endfunction
    function automatic logic [10:0] y_of(input int i);
        return bus.topLeftY[11*i +: 11];
    endfunction
    function automatic logic [1:0] size_of(input int i);
        return bus.ballSize[2*i +: 2];
    endfunction
    function automatic logic signed [15:0] xs_of(input int i);
        return $signed(bus.Xspeed[16*i +: 16]);
    endfunction
    function automatic logic signed [15:0] ys_of(input int i);
        return $signed(bus.Yspeed[16*i +: 16]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.startOfFrame  = 1'b0;
        bus.spawn         = 1'b0;
        bus.spawnX        = '0;
        bus.spawnY        = '0;
        bus.spawnSize     = '0;
        bus.spawnDirRight = 1'b0;
        bus.hitValid      = 1'b0;
        bus.hitIdx        = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic spawn_ball(input logic [10:0] x, input logic [10:0] y,
                              input logic [1:0] s, input logic dr);
        bus.spawn = 1'b1; bus.spawnX = x; bus.spawnY = y;
        bus.spawnSize = s; bus.spawnDirRight = dr;
        tick();
        bus.spawn = 1'b0;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic hit(input int idx);
        bus.hitValid = 1'b1;
        bus.hitIdx   = 2'(idx);
        tick();
        bus.hitValid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetN = 1'b0;
        tick();
        total++; if (bus.active !== 4'b0000) $display("FAIL reset_active: got %b want 0000", bus.active); else passed++;
        total++; if (bus.allClear !== 1'b1) $display("FAIL reset_allclear: got %b want 1", bus.allClear); else passed++;
        total++; if (bus.topLeftX !== '0 || bus.topLeftY !== '0) $display("FAIL reset_pos: got %h/%h want 0", bus.topLeftX, bus.topLeftY); else passed++;
        total++; if (bus.Xspeed !== '0 || bus.Yspeed !== '0 || bus.ballSize !== '0) $display("FAIL reset_speed: got %h/%h/%h want 0", bus.Xspeed, bus.Yspeed, bus.ballSize); else passed++;
        total++; if (bus.spawnFail !== 1'b0 || bus.splitFail !== 1'b0) $display("FAIL reset_fail_pulses: got %b%b want 00", bus.spawnFail, bus.splitFail); else passed++;
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_spawn_move();
        apply_reset();
        spawn_ball(11'd100, 11'd100, 2'd2, 1'b1);
        total++; if (bus.active !== 4'b0001) $display("FAIL spawn_active: got %b want 0001", bus.active); else passed++;
        total++; if (x_of(0) !== 11'd100 || y_of(0) !== 11'd100) $display("FAIL spawn_pos: got %0d,%0d want 100,100", x_of(0), y_of(0)); else passed++;
        total++; if (ys_of(0) !== 16'sd0 || size_of(0) !== 2'd2) $display("FAIL spawn_state: got ys %0d size %0d want 0 2", ys_of(0), size_of(0)); else passed++;
        total++; if (bus.allClear !== 1'b0) $display("FAIL spawn_allclear: got %b want 0", bus.allClear); else passed++;
        frame();
        total++; if (x_of(0) !== 11'd101 || y_of(0) !== 11'd100) $display("FAIL move_pos: got %0d,%0d want 101,100", x_of(0), y_of(0)); else passed++;
        total++; if (ys_of(0) !== 16'sd1) $display("FAIL move_yspeed: got %0d want 1", ys_of(0)); else passed++;
        total++; if (xs_of(0) !== 16'sd64) $display("FAIL move_xspeed: got %0d want 64", xs_of(0)); else passed++;
    endtask

    task automatic test_walls();
        apply_reset();
        spawn_ball(11'd632, 11'd50, 2'd0, 1'b1);
        spawn_ball(11'd0, 11'd100, 2'd0, 1'b0);
        frame();
        total++; if (x_of(0) !== 11'd632 || xs_of(0) !== -16'sd64) $display("FAIL right_wall: got x %0d xs %0d want 632 -64", x_of(0), xs_of(0)); else passed++;
        total++; if (x_of(1) !== 11'd0 || xs_of(1) !== 16'sd64) $display("FAIL left_wall: got x %0d xs %0d want 0 64", x_of(1), xs_of(1)); else passed++;
        frame();
        total++; if (x_of(0) !== 11'd631) $display("FAIL right_wall_leave: got %0d want 631", x_of(0)); else passed++;
        total++; if (x_of(1) !== 11'd1) $display("FAIL left_wall_leave: got %0d want 1", x_of(1)); else passed++;
    endtask

    task automatic test_floor();
        apply_reset();
        spawn_ball(11'd200, 11'd464, 2'd1, 1'b0);
        frame();
        total++; if (y_of(0) !== 11'd464 || ys_of(0) !== -16'sd320) $display("FAIL floor_bounce: got y %0d ys %0d want 464 -320", y_of(0), ys_of(0)); else passed++;
        total++; if (x_of(0) !== 11'd199) $display("FAIL floor_x: got %0d want 199", x_of(0)); else passed++;
        frame();
        total++; if (y_of(0) !== 11'd459 || ys_of(0) !== -16'sd319) $display("FAIL floor_rise: got y %0d ys %0d want 459 -319", y_of(0), ys_of(0)); else passed++;
    endtask

    task automatic test_split();
        apply_reset();
        spawn_ball(11'd300, 11'd200, 2'd2, 1'b1);
        hit(0);
        total++; if (bus.active !== 4'b0011) $display("FAIL split_active: got %b want 0011", bus.active); else passed++;
        total++; if (size_of(0) !== 2'd1 || xs_of(0) !== -16'sd64 || ys_of(0) !== -16'sd192) $display("FAIL split_parent: got s %0d xs %0d ys %0d want 1 -64 -192", size_of(0), xs_of(0), ys_of(0)); else passed++;
        total++; if (size_of(1) !== 2'd1 || xs_of(1) !== 16'sd64 || ys_of(1) !== -16'sd192) $display("FAIL split_child: got s %0d xs %0d ys %0d want 1 64 -192", size_of(1), xs_of(1), ys_of(1)); else passed++;
        total++; if (x_of(0) !== 11'd300 || y_of(0) !== 11'd200 || x_of(1) !== 11'd300 || y_of(1) !== 11'd200) $display("FAIL split_pos: got %0d,%0d %0d,%0d want 300,200 both", x_of(0), y_of(0), x_of(1), y_of(1)); else passed++;
        total++; if (bus.splitFail !== 1'b0) $display("FAIL split_no_fail: got %b want 0", bus.splitFail); else passed++;
    endtask

    task automatic test_ceiling();
        apply_reset();
        spawn_ball(11'd100, 11'd1, 2'd1, 1'b1);
        hit(0);
        frame();
        total++; if (y_of(0) !== 11'd0 || ys_of(0) !== 16'sd0) $display("FAIL ceiling_parent: got y %0d ys %0d want 0 0", y_of(0), ys_of(0)); else passed++;
        total++; if (x_of(0) !== 11'd99 || x_of(1) !== 11'd101) $display("FAIL ceiling_x: got %0d,%0d want 99,101", x_of(0), x_of(1)); else passed++;
        total++; if (y_of(1) !== 11'd0 || ys_of(1) !== 16'sd0) $display("FAIL ceiling_child: got y %0d ys %0d want 0 0", y_of(1), ys_of(1)); else passed++;
    endtask

    task automatic test_full_pool();
        apply_reset();
        spawn_ball(11'd10,  11'd10, 2'd1, 1'b1);
        spawn_ball(11'd100, 11'd10, 2'd1, 1'b1);
        spawn_ball(11'd200, 11'd10, 2'd1, 1'b1);
        spawn_ball(11'd300, 11'd10, 2'd1, 1'b1);
        total++; if (bus.active !== 4'b1111) $display("FAIL full_active: got %b want 1111", bus.active); else passed++;
        hit(2);
        total++; if (bus.splitFail !== 1'b1) $display("FAIL split_fail_pulse: got %b want 1", bus.splitFail); else passed++;
        total++; if (size_of(2) !== 2'd0 || ys_of(2) !== -16'sd192 || bus.active !== 4'b1111) $display("FAIL split_fail_shrink: got s %0d ys %0d act %b want 0 -192 1111", size_of(2), ys_of(2), bus.active); else passed++;
        tick();
        total++; if (bus.splitFail !== 1'b0) $display("FAIL split_fail_width: got %b want 0", bus.splitFail); else passed++;
        spawn_ball(11'd500, 11'd400, 2'd3, 1'b0);
        total++; if (bus.spawnFail !== 1'b1) $display("FAIL spawn_fail_pulse: got %b want 1", bus.spawnFail); else passed++;
        total++; if (bus.active !== 4'b1111 || x_of(3) !== 11'd300 || size_of(3) !== 2'd1) $display("FAIL spawn_fail_state: got act %b x %0d s %0d want 1111 300 1", bus.active, x_of(3), size_of(3)); else passed++;
        tick();
        total++; if (bus.spawnFail !== 1'b0) $display("FAIL spawn_fail_width: got %b want 0", bus.spawnFail); else passed++;
    endtask

    task automatic test_priority();
        apply_reset();
        spawn_ball(11'd100, 11'd100, 2'd2, 1'b1);
        spawn_ball(11'd400, 11'd100, 2'd0, 1'b1);
        bus.hitValid = 1'b1; bus.hitIdx = 2'd0;
        bus.spawn = 1'b1; bus.spawnX = 11'd20; bus.spawnY = 11'd20;
        bus.spawnSize = 2'd0; bus.spawnDirRight = 1'b0;
        bus.startOfFrame = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.active !== 4'b1111) $display("FAIL prio_active: got %b want 1111", bus.active); else passed++;
        total++; if (x_of(0) !== 11'd100 || ys_of(0) !== -16'sd192 || size_of(0) !== 2'd1) $display("FAIL prio_hit_slot: got x %0d ys %0d s %0d want 100 -192 1", x_of(0), ys_of(0), size_of(0)); else passed++;
        total++; if (x_of(1) !== 11'd401 || ys_of(1) !== 16'sd1) $display("FAIL prio_frame_slot: got x %0d ys %0d want 401 1", x_of(1), ys_of(1)); else passed++;
        total++; if (x_of(2) !== 11'd100 || y_of(2) !== 11'd100 || xs_of(2) !== 16'sd64) $display("FAIL prio_child_slot: got %0d,%0d xs %0d want 100,100 64", x_of(2), y_of(2), xs_of(2)); else passed++;
        total++; if (x_of(3) !== 11'd20 || y_of(3) !== 11'd20 || ys_of(3) !== 16'sd0 || xs_of(3) !== -16'sd64) $display("FAIL prio_spawn_slot: got %0d,%0d ys %0d xs %0d want 20,20 0 -64", x_of(3), y_of(3), ys_of(3), xs_of(3)); else passed++;
    endtask

    task automatic test_clear_and_reset();
        apply_reset();
        spawn_ball(11'd50, 11'd50, 2'd0, 1'b1);
        bus.hitValid = 1'b1; bus.hitIdx = 2'd0; bus.startOfFrame = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.active !== 4'b0000 || bus.allClear !== 1'b1) $display("FAIL destroy: got act %b clr %b want 0000 1", bus.active, bus.allClear); else passed++;
        total++; if (x_of(0) !== 11'd0 || ys_of(0) !== 16'sd0) $display("FAIL destroy_outputs: got x %0d ys %0d want 0 0", x_of(0), ys_of(0)); else passed++;
        hit(3);
        total++; if (bus.active !== 4'b0000 || bus.splitFail !== 1'b0) $display("FAIL hit_inactive: got act %b sf %b want 0000 0", bus.active, bus.splitFail); else passed++;
        spawn_ball(11'd50, 11'd50, 2'd0, 1'b1);
        frame();
        frame();
        total++; if (x_of(0) !== 11'd52) $display("FAIL pre_reset_motion: got %0d want 52", x_of(0)); else passed++;
        #3;
        resetN = 1'b0;
        #1;
        total++; if (bus.active !== 4'b0000 || bus.allClear !== 1'b1) $display("FAIL async_reset_active: got act %b clr %b want 0000 1", bus.active, bus.allClear); else passed++;
        total++; if (bus.topLeftX !== '0 || bus.topLeftY !== '0 || bus.Xspeed !== '0 || bus.Yspeed !== '0) $display("FAIL async_reset_outputs: got %h %h %h %h want 0", bus.topLeftX, bus.topLeftY, bus.Xspeed, bus.Yspeed); else passed++;
        tick();
        resetN = 1'b1;
        tick();
        spawn_ball(11'd50, 11'd50, 2'd0, 1'b1);
        tick();
        total++; if (x_of(0) !== 11'd50 || y_of(0) !== 11'd50) $display("FAIL no_motion_without_frame: got %0d,%0d want 50,50", x_of(0), y_of(0)); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        resetN = 1'b0;
        idle_inputs();
        test_reset();
        test_spawn_move();
        test_walls();
        test_floor();
        test_split();
        test_ceiling();
        test_full_pool();
        test_priority();
        test_clear_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ball_pool_move.md
# ball_pool_move

Multi-ball motion engine for up to NUM_BALLS bouncing balls with per-slot size, gravity, wall/floor/ceiling handling and hit-driven splitting. It advances every active ball once per startOfFrame in fixed-point, creates balls on spawn requests, and splits or destroys a ball on a hit report. It feeds the ball drawers and collision logic, which consume per-slot integer top-left coordinates, size and speed.

## Interface
Parameters:
- NUM_BALLS, 4, number of ball slots (2..16)
- FRAC_BITS, 6, fractional bits of internal position/speed
- X_MIN / X_MAX, 0 / 639, horizontal playfield limits (pixels, inclusive)
- Y_MIN / Y_MAX, 0 / 479, vertical playfield limits (pixels, inclusive)
- MIN_DIAM, 8, diameter of size 0; size s diameter = MIN_DIAM << s
- GRAVITY, 1, Yspeed increment per frame (fractional units)
- X_SPEED, 64, horizontal speed magnitude (fractional units/frame)
- BOUNCE_BASE / BOUNCE_STEP, 256 / 64, floor rebound magnitude = BOUNCE_BASE + s*BOUNCE_STEP
- SPLIT_SPEED, 192, upward speed magnitude given to both split children
- MAX_YSPEED, 512, Yspeed clamp magnitude

Ports:
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per frame
- spawn  in  1  one-cycle request to create a ball
- spawnX, spawnY  in  11  spawn top-left, pixels
- spawnSize  in  2  spawn size 0..3
- spawnDirRight  in  1  1 = initial X motion rightwards
- hitValid  in  1  one-cycle hit report
- hitIdx  in  $clog2(NUM_BALLS)  slot that was hit
- active  out  NUM_BALLS  per-slot valid
- topLeftX, topLeftY  out  NUM_BALLS*11  packed, slot i at [11i+10:11i]
- ballSize  out  NUM_BALLS*2  packed sizes
- Xspeed, Yspeed  out  NUM_BALLS*16  packed signed, fractional units
- allClear  out  1  no slot active
- spawnFail, splitFail  out  1  one-cycle error pulses

## Operation
- Per slot state: active, size, dirRight, signed 32-bit posX/posY and Yspeed, all scaled by 2^FRAC_BITS.
- Reset: all slots inactive, state zero; all outputs 0 except allClear = 1.
- Inactive slots drive 0 on every packed output field.
- Xspeed field = dirRight ? +X_SPEED : -X_SPEED; topLeft = pos >> FRAC_BITS.
- Spawn: lowest-index free slot loaded with (spawnX, spawnY) << FRAC_BITS, spawnSize, spawnDirRight, Yspeed 0. No free slot: request dropped, spawnFail pulses.
- Hit on active slot i, size s > 0: slot i becomes size s-1, dirRight 0, Yspeed -SPLIT_SPEED; lowest free slot j gets the same position, size s-1, dirRight 1, Yspeed -SPLIT_SPEED. No free slot: slot i still shrinks, splitFail pulses.
- Hit on size 0: slot i deactivated. Hit on inactive slot or hitIdx >= NUM_BALLS: ignored.
- Frame update per active slot, in order: Yspeed += GRAVITY, clamp to +-MAX_YSPEED; nx = posX +- X_SPEED; ny = posY + Yspeed.
- Right limit R = (X_MAX - diam + 1); floor F = (Y_MAX - diam + 1); both << FRAC_BITS.
- nx >= R while moving right: posX = R, dirRight 0. nx <= X_MIN<<F while moving left: posX = X_MIN<<F, dirRight 1.
- ny >= F and Yspeed > 0: posY = F, Yspeed = -(BOUNCE_BASE + s*BOUNCE_STEP). ny <= Y_MIN<<F and Yspeed < 0: posY = Y_MIN<<F, Yspeed = 0.
- Same-cycle priority: hit, then spawn (spawn takes lowest free slot not claimed by the split), then frame update. Frame update applies only to slots active and not hit at the start of the cycle; newly created/shrunk balls first move on the next startOfFrame.

## Timing
- All state registered; every event takes effect on the clk edge where it is sampled; outputs change the following cycle.
- spawnFail/splitFail high exactly one cycle after the offending request.
- allClear is combinational from the active register.
- resetN asserted mid-frame clears everything immediately; first motion occurs on the first startOfFrame after release.

## Test plan
- Spawn (100,100) size 2 dirRight, one frame -> active[0]=1, topLeftX 101, topLeftY 100, Yspeed 1, Xspeed 64.
- Spawn size 0 at X 632 dirRight, one frame -> topLeftX 632, Xspeed -64; next frame topLeftX 631.
- Spawn size 1 at Y 464, one frame -> topLeftY 464, Yspeed -320; next frame Yspeed -319, topLeftY 459.
- Slot 0 size 2 active, hit idx 0 -> slot0 size1 Xspeed -64 Yspeed -192; slot1 active size1 Xspeed 64 Yspeed -192, identical position.
- All 4 slots active: hit size 1 -> splitFail pulse, slot size 0, no new slot; spawn -> spawnFail pulse, state unchanged.
- Sole ball size 0, hit with simultaneous startOfFrame -> active 0, allClear 1; then resetN pulse mid-motion -> all outputs 0, allClear 1.
